// File: rtl/line_buffer_wr_ctrl.sv
// line_buffer_wr_ctrl: turns a raster pixel stream into line buffer write strobes.
// Build option LBC_DROP_CNT_EN: count pixels discarded while idle.
module line_buffer_wr_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_LINES  = 4,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int RD_LATENCY = 1,
    localparam int HW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_sof,
    output logic                  s_ready,
    output logic                  lb_we,
    output logic [13:0]           lb_wr_addr,
    output logic [DATA_WIDTH-1:0] lb_data,
    output logic                  lb_eol,
    output logic                  lb_ready,
    output logic                  col_valid,
    output logic [13:0]           col_x,
    output logic [15:0]           col_y,
    output logic [HW-1:0]         col_head,
    output logic [DATA_WIDTH-1:0] col_pixel,
    output logic                  frame_done,
    output logic                  err_sof,
    output logic [15:0]           drop_cnt
);

    localparam logic [13:0]   XMAX  = 14'(IMG_WIDTH - 1);
    localparam logic [15:0]   YMAX  = 16'(IMG_HEIGHT - 1);
    localparam logic [15:0]   YRD   = 16'(NUM_LINES - 1);
    localparam logic [HW-1:0] WLMAX = HW'(NUM_LINES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_EOL} state_t;

    state_t          r_state, w_next;
    logic [13:0]     r_x;
    logic [15:0]     r_y;
    logic [HW-1:0]   r_wl, w_wl_nxt;
    logic            r_abort, r_err, r_eol, r_last, r_fd;
    logic            w_ready, w_abort, w_acc, w_wr;
    logic [13:0]     w_wx;
    logic [15:0]     w_wy;

    logic                  r_lb_we, r_lb_ready;
    logic [13:0]           r_lb_addr;
    logic [DATA_WIDTH-1:0] r_lb_data;
    logic [15:0]           r_s1_y;
    logic [HW-1:0]         r_s1_head;

    logic                  r_cv [RD_LATENCY];
    logic [13:0]           r_cx [RD_LATENCY];
    logic [15:0]           r_cy [RD_LATENCY];
    logic [DATA_WIDTH-1:0] r_cp [RD_LATENCY];
    logic [HW-1:0]         r_ch [RD_LATENCY];

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_abort = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (s_valid && s_sof) w_next = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (s_valid && s_sof) begin
                    w_abort = 1'b1;
                    w_next  = S_EOL;
                end else begin
                    w_ready = 1'b1;
                    if (s_valid && r_x == XMAX) w_next = S_EOL;
                end
            end
            S_EOL: w_next = (r_abort || r_y == YMAX) ? S_IDLE : S_ACTIVE;
            default: w_next = S_IDLE;
        endcase
    end

    assign s_ready  = w_ready & reset_n;
    assign w_acc    = s_valid & s_ready;
    assign w_wr     = w_acc & ((r_state == S_ACTIVE) | s_sof);
    assign w_wx     = (r_state == S_ACTIVE) ? r_x : '0;
    assign w_wy     = (r_state == S_ACTIVE) ? r_y : '0;
    assign w_wl_nxt = (r_wl == WLMAX) ? '0 : r_wl + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_wl    <= '0;
            r_abort <= 1'b0;
            r_err   <= 1'b0;
            r_eol   <= 1'b0;
            r_last  <= 1'b0;
            r_fd    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_eol   <= (r_state == S_EOL);
            r_last  <= (r_state == S_EOL) && !r_abort && (r_y == YMAX);
            r_fd    <= r_last;
            if (w_abort) begin
                r_abort <= 1'b1;
                r_err   <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_wr) begin
                        r_x <= 14'd1;
                        r_y <= '0;
                    end
                end
                S_ACTIVE: begin
                    if (w_acc && r_x != XMAX) r_x <= r_x + 1'b1;
                end
                S_EOL: begin
                    // wl tracks the buffer line pointer the next write will hit
                    r_x     <= '0;
                    r_wl    <= w_wl_nxt;
                    r_abort <= 1'b0;
                    r_y     <= (w_next == S_ACTIVE) ? r_y + 1'b1 : '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lb_we    <= 1'b0;
            r_lb_ready <= 1'b0;
            r_lb_addr  <= '0;
            r_lb_data  <= '0;
            r_s1_y     <= '0;
            r_s1_head  <= '0;
        end else begin
            r_lb_we    <= w_wr;
            r_lb_ready <= w_wr && (w_wy >= YRD);
            if (w_wr) begin
                r_lb_addr <= w_wx;
                r_lb_data <= s_data;
                r_s1_y    <= w_wy;
                r_s1_head <= w_wl_nxt;
            end
        end
    end

    // column metadata follows lb_ready through the buffer read latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_cv[i] <= 1'b0;
                r_cx[i] <= '0;
                r_cy[i] <= '0;
                r_cp[i] <= '0;
                r_ch[i] <= '0;
            end
        end else begin
            r_cv[0] <= r_lb_ready;
            r_cx[0] <= r_lb_addr;
            r_cy[0] <= r_s1_y;
            r_cp[0] <= r_lb_data;
            r_ch[0] <= r_s1_head;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_cv[i] <= r_cv[i-1];
                r_cx[i] <= r_cx[i-1];
                r_cy[i] <= r_cy[i-1];
                r_cp[i] <= r_cp[i-1];
                r_ch[i] <= r_ch[i-1];
            end
        end
    end

`ifdef LBC_DROP_CNT_EN
    logic        w_drop;
    logic [15:0] r_drop;

    assign w_drop = w_acc && (r_state == S_IDLE) && !s_sof;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_drop <= '0;
        else if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 1'b1;
    end

    assign drop_cnt = r_drop;
`else
    assign drop_cnt = '0;
`endif

    assign lb_we      = r_lb_we;
    assign lb_ready   = r_lb_ready;
    assign lb_wr_addr = r_lb_addr;
    assign lb_data    = r_lb_data;
    assign lb_eol     = r_eol;
    assign col_valid  = r_cv[RD_LATENCY-1];
    assign col_x      = r_cx[RD_LATENCY-1];
    assign col_y      = r_cy[RD_LATENCY-1];
    assign col_pixel  = r_cp[RD_LATENCY-1];
    assign col_head   = r_ch[RD_LATENCY-1];
    assign frame_done = r_fd;
    assign err_sof    = r_err;

endmodule

// File: doc/line_buffer_wr_ctrl.md
Name: line_buffer_wr_ctrl

Overview:
- Write-side controller that drives the CNN line buffer from a raster pixel stream.
- Accepts pixels over a valid/ready handshake and generates the buffer's we, wr_addr, data_in, eol and ready strobes.
- Tracks which buffer line is being written, and emits column-valid and position metadata aligned to the buffer's data_out so the downstream window/conv stage can consume columns.

Parameters:
DATA_WIDTH, 16, pixel width in bits.
NUM_LINES, 4, number of buffer lines. Must match the line buffer instance.
IMG_WIDTH, 64, pixels per line, 2..16384.
IMG_HEIGHT, 64, lines per frame, >= NUM_LINES.
RD_LATENCY, 1, buffer read latency in cycles, from lb_ready to data_out valid.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
s_valid  in  1  input pixel valid
s_data  in  DATA_WIDTH  input pixel
s_sof  in  1  start-of-frame; qualifies the first pixel of a frame
s_ready  out  1  controller accepts pixel this cycle
lb_we  out  1  buffer write enable
lb_wr_addr  out  14  buffer write address (column)
lb_data  out  DATA_WIDTH  buffer write data
lb_eol  out  1  end-of-line strobe to the buffer
lb_ready  out  1  buffer read-advance strobe
col_valid  out  1  buffer data_out holds a valid column this cycle
col_x  out  14  column index of the valid column
col_y  out  16  row index of the line currently being written
col_head  out  max(1,clog2(NUM_LINES))  buffer line index of the oldest line (rotation)
col_pixel  out  DATA_WIDTH  current-row pixel aligned with col_valid
frame_done  out  1  one-cycle pulse after the last eol of a frame
err_sof  out  1  sticky: s_sof seen mid-frame; cleared only by reset
drop_cnt  out  16  see Optional Feature

Behaviour:
- Accept condition: s_valid && s_ready. s_ready is forced 0 while reset_n is low.

- State machine:
  - IDLE: s_ready=1. Non-sof pixels are accepted and discarded. An accepted sof pixel is written at x=0, y=0, and the FSM moves to ACTIVE.
  - ACTIVE: s_ready=1 except on abort (below). Each accepted pixel is written at column x, then x increments. Accepting x==IMG_WIDTH-1 moves to EOL.
  - EOL: exactly one cycle. s_ready=0, lb_eol=1, lb_we=0, lb_ready=0; x clears to 0 and wl advances modulo NUM_LINES. If y==IMG_HEIGHT-1, frame_done pulses on the next cycle and the FSM returns to IDLE. Otherwise y increments and the FSM returns to ACTIVE.
- Result: one bubble cycle per line. eol is never asserted in the same cycle as we or ready.

- Write path:
  - lb_we, lb_wr_addr, lb_data and lb_ready are registered, appearing 1 cycle after acceptance.
  - lb_wr_addr = x zero-extended to 14 bits.
- lb_ready pulses with lb_we whenever y >= NUM_LINES-1. This keeps the buffer read address equal to x.
- wl mirrors the buffer's current-line pointer: both are 0 after reset, and wl advances only on lb_eol.

- Column path:
  - col_valid = lb_ready delayed RD_LATENCY cycles.
  - col_x, col_y, col_pixel and col_head travel in the same pipeline.
  - col_head = (wl+1) mod NUM_LINES, sampled at acceptance.
  - The buffer slice at index wl is stale, because it is being written that cycle. Downstream substitutes col_pixel for it.

- Abort:
  - Trigger: s_valid && s_sof in ACTIVE.
  - Response: s_ready=0 that cycle, err_sof set, transition to EOL, then force return to IDLE with no frame_done.
  - The sof pixel is then accepted in IDLE on the following cycle.

- Reset (asynchronous, including mid-frame):
  - FSM to IDLE; x, y, wl and the whole pipeline cleared.
  - All outputs 0: lb_*, col_*, frame_done, err_sof, drop_cnt.
  - The system must reset the line buffer concurrently.

- Widths: x is 14 bits, y is 16 bits, wl wraps modulo NUM_LINES. No arithmetic overflow is possible within the parameter limits.

Optional Feature:
- Macro LBC_DROP_CNT_EN.
- Defined: drop_cnt is a 16-bit counter of pixels discarded in IDLE. It saturates at 16'hFFFF and clears on reset.
- Undefined: drop_cnt is tied to 0 and the counter logic is absent.

Test Plan:
Common setup: IMG_WIDTH=8, IMG_HEIGHT=6, NUM_LINES=4, RD_LATENCY=1.

1. Assert reset_n=0 mid-line with s_valid=1 -> all outputs 0 and s_ready=0. On release, the FSM is in IDLE with s_ready=1.
2. Stream a full frame with s_valid held at 1 -> 48 lb_we pulses with lb_wr_addr 0..7 repeating; 6 lb_eol pulses, each with s_ready=0 for 1 cycle; lb_ready only on rows 3..5 (24 pulses); col_head = 0,1,2 on rows 3,4,5; frame_done 1 cycle after the 6th eol.
3. Row 3, x=5, accepted at cycle T -> lb_we and lb_ready at T+1 with lb_wr_addr=5; col_valid at T+2 with col_x=5, col_y=3 and col_pixel equal to that pixel.
4. s_sof at row 2, x=4 -> s_ready=0, err_sof=1, one lb_eol; the next cycle is IDLE and the sof pixel is written at addr 0; no frame_done.
5. Three non-sof pixels in IDLE -> no lb_we. drop_cnt=3 with LBC_DROP_CNT_EN defined, 0 without it.
6. Random s_valid gaps (50%) over a frame -> the same 48 writes, address order and eol count as scenario 2; lb_ready count = 24.
